// File: rtl/subadd_serial_ctrl.sv
// Wide add/subtract sequenced through one 4-bit add/sub slice, one nibble per clock, LSB first.
// Optional SUBADD_SEQ_SAT_EN: saturate the result on signed overflow when entering DONE.
module subadd_serial_ctrl #(
    parameter int NIBBLES = 4,
    localparam int W      = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         overflow,
    output logic         zero,
    output logic [1:0]   fsm_state
);

    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          sub_reg;
    logic          c_reg;

    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [4:0]    sum;
    logic [W-1:0]  res_next;
    logic [W-1:0]  fin_res;
    logic          ovf_next;
    logic          last;

    // Handshake: start is sampled only in IDLE; done pulses for the single DONE
    // cycle, during which result/carry/overflow/zero are valid; busy covers RUN and DONE.
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign fsm_state = state;
    assign last      = (cnt == CW'(NIBBLES - 1));

    always_comb begin
        a_nib    = a_reg[{cnt, 2'b00} +: 4];
        b_nib    = b_reg[{cnt, 2'b00} +: 4] ^ {4{sub_reg}};
        sum      = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, c_reg};
        res_next = result;
        res_next[{cnt, 2'b00} +: 4] = sum[3:0];
        // Signed overflow: operands agree in sign but the sum does not.
        ovf_next = (a_reg[W-1] == (b_reg[W-1] ^ sub_reg)) && (res_next[W-1] != a_reg[W-1]);
        fin_res  = res_next;
`ifdef SUBADD_SEQ_SAT_EN
        if (ovf_next) begin
            fin_res = a_reg[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            sub_reg  <= 1'b0;
            c_reg    <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        sub_reg <= sub;
                        cnt     <= '0;
                        // Carry-in of 1 supplies the +1 of the two's complement negation.
                        c_reg   <= sub;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    c_reg <= sum[4];
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        result   <= fin_res;
                        carry    <= sum[4];
                        overflow <= ovf_next;
                        zero     <= ~|fin_res;
                        state    <= DONE;
                    end else begin
                        result <= res_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subadd_serial_ctrl.sv
// Bench for subadd_serial_ctrl: directed corner vectors plus random operations
// checked against a whole-word arithmetic model of the add/subtract.
module tb_subadd_serial_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic [1:0]   fsm_state;

    int n_checks;
    int n_errors;

    subadd_serial_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .fsm_state (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain W-bit arithmetic on whole words.
    task automatic model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic c, output logic v, output logic z);
        logic [W:0]   full;
        logic [W-1:0] yeff;
        yeff = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yeff} + (W+1)'(s);
        r    = full[W-1:0];
        c    = full[W];
        v    = (x[W-1] == yeff[W-1]) && (r[W-1] != x[W-1]);
`ifdef SUBADD_SEQ_SAT_EN
        if (v) r = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        z = (r == '0);
    endtask

    // One operation; inputs and start are scrambled while busy to prove they are ignored.
    task automatic do_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] er;
        logic         ec, ev, ez;
        int           edges;
        int           busy_cnt;
        model(s, x, y, er, ec, ev, ez);
        @(posedge clk); #1;
        start = 1'b1; sub = s; a = x; b = y;
        @(posedge clk); #1;
        edges    = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && edges < 20) begin
            start = 1'($urandom_range(0, 1));
            sub   = 1'($urandom_range(0, 1));
            a     = W'($urandom);
            b     = W'($urandom);
            @(posedge clk); #1;
            edges++;
            if (busy) busy_cnt++;
        end
        check("done_seen", done, 1'b1);
        check("latency", edges, NIBBLES + 1);
        check("busy_cycles", busy_cnt, NIBBLES + 1);
        check("result", result, er);
        check("carry", carry, ec);
        check("overflow", overflow, ev);
        check("zero", zero, ez);
        @(posedge clk); #1;
        start = 1'b0;
        check("done_pulse_end", done, 1'b0);
        check("idle_after_done", busy, 1'b0);
        check("result_held", result, er);
    endtask

    initial begin
        int t1;
        int t2;
        int dcnt;
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, '0);
        check("rst_flags", {carry, overflow, zero}, 3'b000);
        rst = 1'b0;

        do_op(1'b0, 16'h1234, 16'h4321);
        do_op(1'b0, 16'h7FFF, 16'h0001);
        do_op(1'b1, 16'h0005, 16'h0005);
        do_op(1'b1, 16'h0000, 16'h0001);
        do_op(1'b1, 16'h8000, 16'h0001);
        do_op(1'b0, 16'hFFFF, 16'h0001);
        do_op(1'b0, 16'h8000, 16'h8000);

        // Asynchronous reset in the middle of RUN.
        @(posedge clk); #1;
        start = 1'b1; sub = 1'b0; a = 16'h1234; b = 16'h4321;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_result", result, '0);
        check("mid_rst_flags", {carry, overflow, zero}, 3'b000);
        @(posedge clk); #1;
        rst  = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) dcnt++;
        end
        check("no_done_after_rst", dcnt, 0);
        do_op(1'b0, 16'h1234, 16'h4321);

        // start held high re-issues on every IDLE cycle.
        @(posedge clk); #1;
        start = 1'b1; sub = 1'b0; a = 16'h0101; b = 16'h0202;
        t1 = -1;
        t2 = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done && t1 < 0) t1 = i;
            else if (done && t2 < 0) t2 = i;
        end
        start = 1'b0;
        check("cont_first_done", t1, NIBBLES + 1);
        check("cont_period", t2 - t1, NIBBLES + 2);
        for (int i = 0; i < 10 && busy; i++) begin
            @(posedge clk); #1;
        end
        check("cont_drained", busy, 1'b0);

        for (int i = 0; i < 150; i++) begin
            do_op(1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
